game_state_ctrl: RTL and testbench
==================================

# game_state_ctrl

Frame-rate game sequencer for the VGA shooter. It sits downstream of the collision and score logic: it consumes `lives` and `score`, plus the start and pause buttons, and runs the attract / start / play / pause / game-over / win flow. It drives a hold-off reset and a run enable back into the object modules, and gives the renderer a state code and a flash bit for banners. Everything runs on the pixel clock. Game decisions are taken only on a one-cycle frame tick derived from `vsync`.

## Interface
Parameters:
- `WIN_SCORE`, default 9: score value (4-bit) that ends the game as a win.
- `OVER_FRAMES`, default 180: frames spent in OVER before auto-return to ATTRACT; range 1..255.
- `RESET_FRAMES`, default 2: frames `game_reset` is held in START; range 1..255.
- `FLASH_FRAMES`, default 30: frames per `flash` half-period; range 1..255.

Ports:
- `clk`  in  1  pixel clock.
- `reset`  in  1  asynchronous, active-high reset.
- `vsync`  in  1  vertical sync from hvsync_generator, same clock domain; its rising edge marks a frame.
- `start_btn`  in  1  raw start button (`ui_in[3]`).
- `pause_btn`  in  1  raw pause button (`ui_in[4]`); used only with `PAUSE_EN`.
- `lives`  in  2  remaining lives from collisions.
- `score`  in  4  current score.
- `state`  out  3  0=ATTRACT, 1=START, 2=PLAYING, 3=PAUSED, 4=OVER, 5=WIN.
- `game_run`  out  1  high only in PLAYING; enables object motion.
- `game_reset`  out  1  high only in START; the top ANDs its inverse into the object `rst_n`.
- `flash`  out  1  banner blink.
- `frame_tick`  out  1  one-cycle frame pulse.

## Operation
Frame tick:
- `vsync_d` is `vsync` registered.
- `frame_tick` is a registered pulse, high for exactly 1 clk in the cycle after `vsync_d` = 0 and `vsync` = 1 is sampled.

Buttons:
- Each button passes through a 2-flop synchronizer.
- The synchronized value is sampled only on `frame_tick`.
- "pressed" = sampled high on two consecutive ticks.
- "edge" = pressed goes 0 to 1. The edge is valid only in a tick cycle.
- Holding a button produces exactly one edge.

State transitions (evaluated only in `frame_tick` cycles):
- ATTRACT: start edge -> START; frame counter cleared.
- START: counter increments each tick. When it reaches `RESET_FRAMES` -> PLAYING.
- PLAYING: priority order is lives, then score, then pause.
  - `lives` == 0 -> OVER.
  - else `score` >= `WIN_SCORE` -> WIN.
  - else pause edge -> PAUSED.
- PAUSED: pause edge -> PLAYING. Start, `lives` and `score` are ignored.
- OVER: start edge -> START, with priority over the timeout. Otherwise, after `OVER_FRAMES` ticks -> ATTRACT.
- WIN: start edge -> START; no timeout.
- Codes 6 and 7 are unreachable; if entered, go to ATTRACT on the next clk.

Frame counter:
- 8 bits.
- Cleared on every state change.
- Saturates at 255.

Flash:
- Separate 8-bit counter.
- Toggles `flash` each time the counter reaches `FLASH_FRAMES` ticks, then the counter clears.
- Active in ATTRACT, OVER and WIN.
- Forced to 0 with the counter cleared in START, PLAYING and PAUSED.

## Timing
- Reset values:
  - `state` = 0 (ATTRACT)
  - `game_run` = 0, `game_reset` = 0, `flash` = 0, `frame_tick` = 0
  - all counters, synchronizers and button history = 0
- Reset asserted mid-game returns to ATTRACT immediately and asynchronously.
- All outputs are registered.
- `state`, `game_run` and `game_reset` change in the clk after the `frame_tick` cycle that decides the transition.
- Start press to START: at least 2 ticks for the debounce, plus up to 2 clk of synchronizer delay.
- `game_reset` is high for exactly `RESET_FRAMES` frames, which spans at least one `vsync` rising edge seen by the object modules.
- `lives` and `score` are sampled only in tick cycles. Changes between ticks are invisible.

## Configuration
`PAUSE_EN`:
- Defined: the pause button path and the PAUSED state are compiled in.
- Undefined:
  - `pause_btn` is unused.
  - PAUSED is unreachable.
  - PLAYING exits only via lives or score.
  - `state` never reads 3.

## Test plan
- Reset:
  - Assert `reset` mid-frame -> `state`=0, `game_run`=0, `game_reset`=0, `flash`=0 immediately.
  - Release `reset` -> `frame_tick` pulses once per `vsync` rise, width 1 clk.
- Start:
  - Hold `start_btn` high for 3 frames in ATTRACT -> `state`=1 after tick 2.
  - `game_reset`=1 for exactly 2 frames, then `state`=2 with `game_run`=1.
  - Keep holding the button -> no further edge.
- Game over:
  - In PLAYING, drive `lives`=0 -> OVER on the next tick.
  - No press -> `state`=0 after 180 ticks.
  - A press at tick 50 -> START instead.
- Priority:
  - In PLAYING, drive `lives`=0 and `score`=9 on the same tick -> `state`=4, not 5.
  - `lives`=2 with `score`=9 -> `state`=5, `flash` toggling every 30 ticks.
- Pause (`PAUSE_EN` defined):
  - Pause edge -> `state`=3, `game_run`=0.
  - `lives`=0 while paused -> no transition.
  - Second pause edge -> PLAYING, then OVER on the next tick.
  - With `PAUSE_EN` undefined, the same stimulus leaves `state`=2.
- Glitch rejection:
  - A 1-frame `start_btn` pulse, or a pulse entirely between two ticks -> no transition from ATTRACT.

Source files
------------

// File: rtl/game_state_ctrl.sv
// Frame-rate game sequencer: attract / start / play / pause / over / win flow driven by vsync frame ticks.
// Optional pause feature is compiled in with `define PAUSE_EN.
module game_state_ctrl #(
    parameter int WIN_SCORE    = 9,
    parameter int OVER_FRAMES  = 180,
    parameter int RESET_FRAMES = 2,
    parameter int FLASH_FRAMES = 30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       vsync,
    input  logic       start_btn,
    input  logic       pause_btn,
    input  logic [1:0] lives,
    input  logic [3:0] score,
    output logic [2:0] state,
    output logic       game_run,
    output logic       game_reset,
    output logic       flash,
    output logic       frame_tick
);

    typedef enum logic [2:0] {
        ST_ATTRACT = 3'd0,
        ST_START   = 3'd1,
        ST_PLAYING = 3'd2,
        ST_PAUSED  = 3'd3,
        ST_OVER    = 3'd4,
        ST_WIN     = 3'd5
    } state_t;

    localparam logic [3:0] WIN_LIM   = 4'(WIN_SCORE);
    localparam logic [7:0] OVER_LIM  = 8'(OVER_FRAMES);
    localparam logic [7:0] RESET_LIM = 8'(RESET_FRAMES);
    localparam logic [7:0] FLASH_LIM = 8'(FLASH_FRAMES);

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic is_flash_state(input state_t s);
        return (s == ST_ATTRACT) || (s == ST_OVER) || (s == ST_WIN);
    endfunction

    logic       vsync_d;
    logic       start_s1, start_s2, start_h1, start_h2;
    logic       start_edge;
    logic       pause_edge;
    state_t     state_q, state_nxt;
    logic [7:0] frame_cnt, frame_inc;
    logic [7:0] flash_cnt;

    // Frame tick and start-button synchronizer / per-tick history
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vsync_d    <= 1'b0;
            frame_tick <= 1'b0;
            start_s1   <= 1'b0;
            start_s2   <= 1'b0;
            start_h1   <= 1'b0;
            start_h2   <= 1'b0;
        end else begin
            vsync_d    <= vsync;
            frame_tick <= vsync & ~vsync_d;
            start_s1   <= start_btn;
            start_s2   <= start_s1;
            if (frame_tick) begin
                start_h1 <= start_s2;
                start_h2 <= start_h1;
            end
        end
    end

    // Edge: pressed on this tick (two high samples) but not on the previous one
    assign start_edge = frame_tick & start_s2 & start_h1 & ~start_h2;

`ifdef PAUSE_EN
    logic pause_s1, pause_s2, pause_h1, pause_h2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pause_s1 <= 1'b0;
            pause_s2 <= 1'b0;
            pause_h1 <= 1'b0;
            pause_h2 <= 1'b0;
        end else begin
            pause_s1 <= pause_btn;
            pause_s2 <= pause_s1;
            if (frame_tick) begin
                pause_h1 <= pause_s2;
                pause_h2 <= pause_h1;
            end
        end
    end

    assign pause_edge = frame_tick & pause_s2 & pause_h1 & ~pause_h2;
`else
    logic pause_unused;
    assign pause_unused = pause_btn;
    assign pause_edge   = 1'b0;
`endif

    assign frame_inc = sat_inc(frame_cnt);

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_ATTRACT: if (start_edge) state_nxt = ST_START;
            ST_START:   if (frame_tick && (frame_inc >= RESET_LIM)) state_nxt = ST_PLAYING;
            ST_PLAYING: begin
                if (frame_tick) begin
                    if (lives == 2'd0)          state_nxt = ST_OVER;
                    else if (score >= WIN_LIM)  state_nxt = ST_WIN;
                    else if (pause_edge)        state_nxt = ST_PAUSED;
                end
            end
`ifdef PAUSE_EN
            ST_PAUSED:  if (pause_edge) state_nxt = ST_PLAYING;
`endif
            ST_OVER: begin
                if (start_edge)                                     state_nxt = ST_START;
                else if (frame_tick && (frame_inc >= OVER_LIM))     state_nxt = ST_ATTRACT;
            end
            ST_WIN:     if (start_edge) state_nxt = ST_START;
            default:    state_nxt = ST_ATTRACT;
        endcase
    end

    // State register, registered outputs, frame and flash counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_ATTRACT;
            game_run   <= 1'b0;
            game_reset <= 1'b0;
            frame_cnt  <= 8'd0;
            flash_cnt  <= 8'd0;
            flash      <= 1'b0;
        end else begin
            state_q    <= state_nxt;
            game_run   <= (state_nxt == ST_PLAYING);
            game_reset <= (state_nxt == ST_START);

            if (state_nxt != state_q)
                frame_cnt <= 8'd0;
            else if (frame_tick)
                frame_cnt <= frame_inc;

            // The tick that enters a banner state does not count toward the blink period
            if (!is_flash_state(state_nxt)) begin
                flash_cnt <= 8'd0;
                flash     <= 1'b0;
            end else if (frame_tick && is_flash_state(state_q)) begin
                if (sat_inc(flash_cnt) >= FLASH_LIM) begin
                    flash_cnt <= 8'd0;
                    flash     <= ~flash;
                end else begin
                    flash_cnt <= flash_cnt + 8'd1;
                end
            end
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Scoreboard bench for game_state_ctrl: each directed frame pushes the outputs expected after the next tick.
module tb_game_state_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       vsync;
    logic       start_btn;
    logic       pause_btn;
    logic [1:0] lives;
    logic [3:0] score;
    logic [2:0] state;
    logic       game_run;
    logic       game_reset;
    logic       flash;
    logic       frame_tick;

    int n_checks = 0;
    int n_err    = 0;
    int frame_no = 0;

    logic [5:0] exp_q[$];

    logic [2:0] m_state;
    int         fl_cnt;
    logic       fl;

    game_state_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .vsync      (vsync),
        .start_btn  (start_btn),
        .pause_btn  (pause_btn),
        .lives      (lives),
        .score      (score),
        .state      (state),
        .game_run   (game_run),
        .game_reset (game_reset),
        .flash      (flash),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    // vsync: 16-clock frame, high for 3 clocks
    initial begin
        vsync = 1'b0;
        forever begin
            repeat (13) @(negedge clk);
            vsync = 1'b1;
            repeat (3) @(negedge clk);
            vsync = 1'b0;
        end
    end

    function automatic logic flashing(input logic [2:0] s);
        return (s == 3'd0) || (s == 3'd4) || (s == 3'd5);
    endfunction

    task automatic check1(input string name, input logic [7:0] got, input logic [7:0] want);
        n_checks++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    task automatic model_reset();
        m_state = 3'd0;
        fl_cnt  = 0;
        fl      = 1'b0;
    endtask

    task automatic wait_tick();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_tick !== 1'b1 && n < 64);
        if (frame_tick !== 1'b1) begin
            n_checks++;
            n_err++;
            $display("FAIL tick_timeout: no frame_tick within 64 clocks");
        end
        repeat (3) @(negedge clk);
    endtask

    // One directed frame: drive inputs, push outputs expected after the coming tick
    task automatic fr(input logic st, input logic pa, input logic [1:0] lv,
                      input logic [3:0] sc, input logic [2:0] es);
        start_btn = st;
        pause_btn = pa;
        lives     = lv;
        score     = sc;
        if (flashing(es)) begin
            if (flashing(m_state)) begin
                fl_cnt++;
                if (fl_cnt == 30) begin
                    fl     = ~fl;
                    fl_cnt = 0;
                end
            end else begin
                fl_cnt = 0;
            end
        end else begin
            fl_cnt = 0;
            fl     = 1'b0;
        end
        exp_q.push_back({es, (es == 3'd2), (es == 3'd1), fl});
        m_state = es;
        wait_tick();
    endtask

    // Monitor: the clock after each tick, compare the outputs against the next expectation
    initial begin
        logic [5:0] e;
        logic [5:0] g;
        forever begin
            @(negedge clk);
            if (frame_tick === 1'b1) begin
                @(negedge clk);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    g = {state, game_run, game_reset, flash};
                    frame_no++;
                    n_checks++;
                    if (g !== e) begin
                        n_err++;
                        $display("FAIL frame%0d: got state=%0d run=%b rst=%b flash=%b, expected state=%0d run=%b rst=%b flash=%b",
                                 frame_no, g[5:3], g[2], g[1], g[0], e[5:3], e[2], e[1], e[0]);
                    end
                end
            end
        end
    end

    initial begin
        int ticks;
        int dbl;
        logic prev_tick;

        reset = 1'b1;
        start_btn = 1'b0;
        pause_btn = 1'b0;
        lives = 2'd3;
        score = 4'd0;
        model_reset();

        repeat (3) @(negedge clk);
        check1("rst_state", 8'(state), 8'd0);
        check1("rst_run", 8'(game_run), 8'd0);
        check1("rst_greset", 8'(game_reset), 8'd0);
        check1("rst_flash", 8'(flash), 8'd0);
        check1("rst_tick", 8'(frame_tick), 8'd0);
        @(negedge clk);
        reset = 1'b0;

        // frame_tick: one pulse per vsync rise, one clock wide
        ticks = 0;
        dbl = 0;
        prev_tick = 1'b0;
        repeat (160) begin
            @(negedge clk);
            if (frame_tick === 1'b1) ticks++;
            if (frame_tick === 1'b1 && prev_tick === 1'b1) dbl++;
            prev_tick = frame_tick;
        end
        check1("tick_count", 8'(ticks), 8'd10);
        check1("tick_width", 8'(dbl), 8'd0);

        // Fresh start with a known flash phase
        wait_tick();
        @(negedge clk);
        #2 reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();

        // Glitch rejection: one-frame pulse, then a pulse between ticks
        fr(1, 0, 3, 0, 0);
        fr(0, 0, 3, 0, 0);
        fr(0, 0, 3, 0, 0);
        start_btn = 1'b1;
        repeat (3) @(negedge clk);
        start_btn = 1'b0;
        fr(0, 0, 3, 0, 0);
        fr(0, 0, 3, 0, 0);

        // Start held for several frames: one edge, two reset frames, then play
        fr(1, 0, 3, 0, 0);
        fr(1, 0, 3, 0, 1);
        fr(1, 0, 3, 0, 1);
        fr(1, 0, 3, 0, 2);
        fr(1, 0, 3, 0, 2);
        fr(0, 0, 3, 0, 2);

`ifdef PAUSE_EN
        fr(0, 1, 3, 0, 2);
        fr(0, 1, 3, 0, 3);
        fr(0, 1, 0, 0, 3);
        fr(0, 0, 0, 0, 3);
        fr(0, 1, 0, 0, 3);
        fr(0, 1, 0, 0, 2);
        fr(0, 1, 0, 0, 4);
`else
        fr(0, 1, 3, 0, 2);
        fr(0, 1, 3, 0, 2);
        fr(0, 0, 3, 0, 2);
        fr(0, 1, 3, 0, 2);
        fr(0, 1, 3, 0, 2);
        fr(0, 0, 0, 0, 4);
`endif

        // OVER: start edge on tick 50 returns to START
        for (int i = 1; i <= 48; i++) fr(0, 0, 0, 0, 4);
        fr(1, 0, 0, 0, 4);
        fr(1, 0, 0, 0, 1);
        fr(1, 0, 3, 0, 1);
        fr(0, 0, 3, 0, 2);

        // OVER: timeout to ATTRACT after 180 ticks
        fr(0, 0, 0, 0, 4);
        for (int i = 1; i <= 179; i++) fr(0, 0, 0, 0, 4);
        fr(0, 0, 0, 0, 0);

        // Priority: lives beats score
        fr(1, 0, 3, 0, 0);
        fr(1, 0, 3, 0, 1);
        fr(0, 0, 3, 0, 1);
        fr(0, 0, 3, 0, 2);
        fr(0, 0, 0, 9, 4);

        fr(1, 0, 3, 0, 4);
        fr(1, 0, 3, 0, 1);
        fr(0, 0, 3, 0, 1);
        fr(0, 0, 3, 0, 2);
        fr(0, 0, 2, 8, 2);
        fr(0, 0, 2, 9, 5);
        for (int i = 1; i <= 200; i++) fr(0, 0, 2, 9, 5);
        fr(1, 0, 2, 9, 5);
        fr(1, 0, 2, 9, 1);
        fr(1, 0, 3, 0, 1);
        fr(0, 0, 3, 0, 2);

        // Asynchronous reset in the middle of play
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check1("mid_rst_state", 8'(state), 8'd0);
        check1("mid_rst_run", 8'(game_run), 8'd0);
        check1("mid_rst_greset", 8'(game_reset), 8'd0);
        check1("mid_rst_flash", 8'(flash), 8'd0);
        check1("mid_rst_tick", 8'(frame_tick), 8'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
        fr(0, 0, 3, 0, 0);
        fr(0, 0, 3, 0, 0);

        repeat (4) @(negedge clk);
        check1("queue_drained", 8'(exp_q.size()), 8'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
